// File: rtl/aes_axis_pkg.sv
// Shared constants, command codes and FSM state type for the AES AXI-Stream front end.
package aes_axis_pkg;

    localparam int unsigned WORD_S   = 32;
    localparam int unsigned BLK_S    = 128;
    localparam int unsigned KEY_S    = 128;
    localparam int unsigned OUT_WRDS = 4;

    localparam logic [31:0] CMD_SET_KEY = 32'h0000_0020;
    localparam logic [31:0] CMD_ENCRYPT = 32'h0000_0010;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_LOAD,
        ST_KEY,
        ST_RUN,
        ST_SEND
    } state_t;

endpackage

// File: rtl/aes_axis_out_ser.sv
// Load-and-serialize result register with AXI-Stream master handshake.
// Emits the most significant word first; tlast marks the final word.
module aes_axis_out_ser #(
    parameter int unsigned WORD_S = aes_axis_pkg::WORD_S,
    parameter int unsigned N_WRDS = aes_axis_pkg::OUT_WRDS
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load,
    input  logic [WORD_S*N_WRDS-1:0] load_data,
    output logic [WORD_S-1:0]        m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     done
);

    localparam int unsigned SW = WORD_S * N_WRDS;
    localparam int unsigned IW = (N_WRDS > 1) ? $clog2(N_WRDS) : 1;

    logic [SW-1:0] sreg;
    logic [IW-1:0] idx;
    logic          valid;
    logic          hs;
    logic          at_last;

    assign hs            = valid && m_axis_tready;
    assign at_last       = (idx == IW'(N_WRDS - 1));
    assign m_axis_tdata  = sreg[SW-1 -: WORD_S];
    assign m_axis_tvalid = valid;
    assign m_axis_tlast  = valid && at_last;
    assign done          = hs && at_last;

    // Shift register: load a full result, then shift one word out per accepted beat.
    // Shifting in zeros leaves tdata at zero once the frame has drained.
    always_ff @(posedge clock) begin
        if (reset) begin
            sreg  <= '0;
            idx   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            sreg  <= load_data;
            idx   <= '0;
            valid <= 1'b1;
        end else if (hs) begin
            sreg <= {sreg[SW-WORD_S-1:0], {WORD_S{1'b0}}};
            if (at_last) begin
                valid <= 1'b0;
                idx   <= '0;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule

// File: rtl/aes_axis_cmd_frontend.sv
// AXI-Stream command front end for the AES core: parses the command word,
// collects the 128-bit payload, drives the core and streams the result back.
module aes_axis_cmd_frontend #(
    parameter int unsigned WORD_S   = aes_axis_pkg::WORD_S,
    parameter int unsigned BLK_S    = aes_axis_pkg::BLK_S,
    parameter int unsigned OUT_WRDS = aes_axis_pkg::OUT_WRDS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WORD_S-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [WORD_S-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              aes_en,
    output logic [BLK_S-1:0]  aes_key,
    output logic [BLK_S-1:0]  aes_plaintext,
    input  logic              aes_done,
    input  logic [BLK_S-1:0]  aes_ciphertext
);

    import aes_axis_pkg::*;

    localparam int unsigned PAY_WRDS = BLK_S / WORD_S;
    localparam int unsigned CW       = (PAY_WRDS > 1) ? $clog2(PAY_WRDS) : 1;

    state_t            state;
    state_t            state_n;
    logic [WORD_S-1:0] cmd_q;
    logic [CW-1:0]     cnt;
    logic [BLK_S-1:0]  pbuf;
    logic [BLK_S-1:0]  pbuf_shift;
    logic              in_ready;
    logic              s_hs;
    logic              last_word;
    logic              ser_load;
    logic [BLK_S-1:0]  ser_data;
    logic              ser_done;

    // Framing is purely by word count.
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;

    assign s_axis_tready = in_ready;
    assign s_hs          = s_axis_tvalid && in_ready;
    assign pbuf_shift    = {pbuf[BLK_S-WORD_S-1:0], s_axis_tdata};
    assign last_word     = (cnt == CW'(PAY_WRDS - 1));

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_CMD;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode and result selection for the output serializer.
    always_comb begin
        state_n  = state;
        ser_load = 1'b0;
        ser_data = '0;
        unique case (state)
            ST_CMD: begin
                if (s_hs) state_n = ST_LOAD;
            end
            ST_LOAD: begin
                if (s_hs && last_word) begin
                    if (cmd_q == CMD_SET_KEY) begin
                        state_n = ST_KEY;
                    end else if (cmd_q == CMD_ENCRYPT) begin
                        state_n = ST_RUN;
                    end else begin
                        state_n  = ST_SEND;
                        ser_load = 1'b1;
                        ser_data = '1;
                    end
                end
            end
            ST_KEY: begin
                ser_load = 1'b1;
                ser_data = '0;
                state_n  = ST_SEND;
            end
            ST_RUN: begin
                if (aes_done) begin
                    ser_load = 1'b1;
                    ser_data = aes_ciphertext;
                    state_n  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ser_done) state_n = ST_CMD;
            end
            default: state_n = ST_CMD;
        endcase
    end

    // Datapath registers. tready is registered from the next state so it is low
    // during reset and rises the cycle after the final output beat.
    // The payload register is updated on the same edge the FSM enters RUN, so the
    // plaintext is taken from the shifted value rather than the stale buffer.
    always_ff @(posedge clock) begin
        if (reset) begin
            in_ready      <= 1'b0;
            cmd_q         <= '0;
            cnt           <= '0;
            pbuf          <= '0;
            aes_key       <= '0;
            aes_plaintext <= '0;
            aes_en        <= 1'b0;
        end else begin
            in_ready <= (state_n == ST_CMD) || (state_n == ST_LOAD);
            aes_en   <= 1'b0;
            if (state == ST_CMD && s_hs) begin
                cmd_q <= s_axis_tdata;
                cnt   <= '0;
            end
            if (state == ST_LOAD && s_hs) begin
                pbuf <= pbuf_shift;
                cnt  <= cnt + CW'(1);
            end
            if (state == ST_LOAD && state_n == ST_RUN) begin
                aes_plaintext <= pbuf_shift;
                aes_en        <= 1'b1;
            end
            if (state == ST_KEY) begin
                aes_key <= pbuf;
            end
        end
    end

    aes_axis_out_ser #(
        .WORD_S (WORD_S),
        .N_WRDS (OUT_WRDS)
    ) u_out_ser (
        .clock         (clock),
        .reset         (reset),
        .load          (ser_load),
        .load_data     (ser_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .done          (ser_done)
    );

endmodule

// File: tb/tb_aes_axis_cmd_frontend.sv
// Self-checking bench for aes_axis_cmd_frontend with a behavioural AES-128 core model.
module tb_aes_axis_cmd_frontend;

    localparam logic [31:0]  C_SET_KEY = 32'h20;
    localparam logic [31:0]  C_ENC     = 32'h10;
    localparam logic [127:0] K1 = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] P1 = 128'h54776F204F6E65204E696E652054776F;
    localparam logic [127:0] C1 = 128'h29c3505f571420f6402299b31a02d73a;
    localparam logic [127:0] P2 = 128'h12345678911123456789012345678901;

    logic         clock = 1'b0;
    logic         reset;
    logic [31:0]  s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic         aes_en;
    logic [127:0] aes_key;
    logic [127:0] aes_plaintext;
    logic         aes_done;
    logic [127:0] aes_ciphertext;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int          cyc = 0;
    int          done_cyc = -100;
    int          spur_at = -1;
    int          en_count = 0;
    int          core_cnt = 0;
    logic [127:0] core_res;
    logic [7:0]   sbox_t [256];

    aes_axis_cmd_frontend dut (
        .clock          (clock),
        .reset          (reset),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .aes_en         (aes_en),
        .aes_key        (aes_key),
        .aes_plaintext  (aes_plaintext),
        .aes_done       (aes_done),
        .aes_ciphertext (aes_ciphertext)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- AES-128 reference ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic init_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   st [16];
        logic [7:0]   t  [16];
        logic [7:0]   w  [176];
        logic [7:0]   tmp [4];
        logic [7:0]   rc, x, a0, a1, a2, a3;
        logic [127:0] ct;
        for (int i = 0; i < 16; i++) begin
            st[i] = pt[127-8*i -: 8];
            w[i]  = key[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                x      = tmp[0];
                tmp[0] = sbox_t[tmp[1]] ^ rc;
                tmp[1] = sbox_t[tmp[2]];
                tmp[2] = sbox_t[tmp[3]];
                tmp[3] = sbox_t[x];
                rc     = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
        end
        for (int r = 0; r <= 10; r++) begin
            if (r > 0) begin
                for (int i = 0; i < 16; i++) st[i] = sbox_t[st[i]];
                for (int rr = 0; rr < 4; rr++)
                    for (int c = 0; c < 4; c++) t[rr+4*c] = st[rr+4*((c+rr)%4)];
                for (int i = 0; i < 16; i++) st[i] = t[i];
                if (r < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                        st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                        st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                        st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                        st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                    end
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = st[i];
        return ct;
    endfunction

    // AES core model: 10-cycle latency, optional stray aes_done pulse on request.
    initial begin
        aes_done       = 1'b0;
        aes_ciphertext = '0;
        core_res       = '0;
        forever begin
            @(posedge clock); #1;
            aes_done = 1'b0;
            if (reset === 1'b1) begin
                core_cnt = 0;
            end else if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    aes_done       = 1'b1;
                    aes_ciphertext = core_res;
                    done_cyc       = cyc;
                end
            end
            if (cyc == spur_at) begin
                aes_done       = 1'b1;
                aes_ciphertext = {$urandom, $urandom, $urandom, $urandom};
            end
            if (aes_en === 1'b1) begin
                en_count++;
                core_res = aes_encrypt(aes_key, aes_plaintext);
                core_cnt = 10;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_s_tready"}, s_axis_tready, 0);
        chk({tag, "_m_tvalid"}, m_axis_tvalid, 0);
        chk({tag, "_m_tlast"}, m_axis_tlast, 0);
        chk({tag, "_m_tdata"}, m_axis_tdata, 0);
        chk({tag, "_aes_en"}, aes_en, 0);
        chk({tag, "_aes_key"}, aes_key, 0);
        chk({tag, "_aes_pt"}, aes_plaintext, 0);
    endtask

    task automatic send_frame(input logic [31:0] cmd, input logic [127:0] blk,
                              input int nwords, input bit gaps);
        logic [31:0] words [5];
        bit accepted, rdy;
        words[0] = cmd;
        for (int k = 0; k < 4; k++) words[k+1] = blk[127-32*k -: 32];
        for (int k = 0; k < nwords; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    s_axis_tvalid = 1'b0;
                    s_axis_tdata  = $urandom;
                    @(posedge clock); #1;
                end
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = words[k];
            s_axis_tlast  = 1'($urandom_range(0, 1));
            accepted = 1'b0;
            for (int b = 0; b < 50 && !accepted; b++) begin
                rdy = s_axis_tready;
                @(posedge clock); #1;
                if (rdy) accepted = 1'b1;
            end
            chk("in_accept", accepted, 1);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // lat_mode: 0 none, 1 first tvalid two cycles after last payload beat, 2 one cycle after aes_done
    task automatic recv_frame(input logic [127:0] exp, input bit osc, input int lat_mode);
        int k = 0;
        bit stalled = 1'b0;
        bit seen = 1'b0;
        logic [31:0] hold_d;
        logic        hold_l;
        for (int b = 0; b < 400 && k < 4; b++) begin
            m_axis_tready = osc ? ((cyc % 8) >= 2) : 1'b1;
            chk("no_pipeline_tready", s_axis_tready, 0);
            if (stalled) begin
                chk("stall_tvalid", m_axis_tvalid, 1);
                chk("stall_tdata", m_axis_tdata, hold_d);
                chk("stall_tlast", m_axis_tlast, hold_l);
            end
            if (m_axis_tvalid === 1'b1) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (lat_mode == 1) chk("lat_setkey", b, 1);
                    if (lat_mode == 2) chk("lat_encrypt", cyc, done_cyc + 1);
                end
                if (m_axis_tready) begin
                    chk("out_word", m_axis_tdata, exp[127-32*k -: 32]);
                    chk("out_tlast", m_axis_tlast, (k == 3));
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hold_d  = m_axis_tdata;
                    hold_l  = m_axis_tlast;
                end
            end
            @(posedge clock); #1;
        end
        m_axis_tready = 1'b0;
        chk("out_count", k, 4);
        chk("post_tvalid", m_axis_tvalid, 0);
        chk("post_s_tready", s_axis_tready, 1);
    endtask

    // ---------------- directed + randomized sequence ----------------
    initial begin
        logic [127:0] model_key, pt, exp;
        logic [31:0]  cmd;
        int           en0, sel;

        reset         = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        model_key     = '0;
        init_sbox();

        repeat (3) @(posedge clock);
        #1;
        check_reset_vals("rst0");
        reset = 1'b0;

        // SET_KEY answers with zeros and never starts the core
        en0 = en_count;
        send_frame(C_SET_KEY, K1, 5, 1'b0);
        recv_frame('0, 1'b0, 1);
        model_key = K1;
        chk("setkey_no_en", en_count - en0, 0);
        chk("setkey_key", aes_key, model_key);

        // FIPS-consistent encryption
        en0 = en_count;
        send_frame(C_ENC, P1, 5, 1'b0);
        recv_frame(C1, 1'b0, 2);
        chk("enc1_en_once", en_count - en0, 1);
        chk("enc1_pt", aes_plaintext, P1);

        // Second ENCRYPT reuses stored key, with input gaps and stalled output
        en0 = en_count;
        send_frame(C_ENC, P2, 5, 1'b1);
        recv_frame(aes_encrypt(model_key, P2), 1'b1, 2);
        chk("enc2_en_once", en_count - en0, 1);
        chk("enc2_key_kept", aes_key, model_key);

        // Stray aes_done while idle must not produce output
        spur_at = cyc + 1;
        repeat (4) @(posedge clock);
        #1;
        chk("spur_tvalid", m_axis_tvalid, 0);

        // Unknown command answers all-ones
        en0 = en_count;
        send_frame(32'hDEADBEEF, {$urandom, $urandom, $urandom, $urandom}, 5, 1'b1);
        recv_frame('1, 1'b1, 0);
        chk("unk_no_en", en_count - en0, 0);

        en0 = en_count;
        send_frame(C_ENC, P1, 5, 1'b0);
        recv_frame(C1, 1'b0, 2);
        chk("enc3_en_once", en_count - en0, 1);

        // Reset in the middle of a payload
        send_frame(C_SET_KEY, {$urandom, $urandom, $urandom, $urandom}, 3, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        check_reset_vals("rst_mid");
        @(posedge clock); #1;
        reset = 1'b0;
        model_key = '0;

        pt = {$urandom, $urandom, $urandom, $urandom};
        send_frame(C_SET_KEY, pt, 5, 1'b0);
        recv_frame('0, 1'b0, 1);
        model_key = pt;
        chk("rst_setkey_key", aes_key, model_key);

        // Randomized command mix against the rule-level model
        for (int f = 0; f < 12; f++) begin
            sel = $urandom_range(0, 2);
            pt  = {$urandom, $urandom, $urandom, $urandom};
            if (sel == 0) begin
                cmd = C_SET_KEY; exp = '0;
            end else if (sel == 1) begin
                cmd = C_ENC; exp = aes_encrypt(model_key, pt);
            end else begin
                cmd = $urandom;
                if (cmd == C_SET_KEY || cmd == C_ENC) cmd = 32'hFFFF_0000;
                exp = '1;
            end
            en0 = en_count;
            send_frame(cmd, pt, 5, 1'b1);
            recv_frame(exp, 1'($urandom_range(0, 1)), (sel == 2) ? 0 : sel + 1);
            chk("rand_en_count", en_count - en0, (sel == 1) ? 1 : 0);
            if (sel == 0) model_key = pt;
            chk("rand_key", aes_key, model_key);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
